// File: rtl/axis_sample_unpacker_if.sv
// Bus bundles for axis_sample_unpacker.
//   unpacker_axis_if : AXI4-Stream beat channel (master = DMA source, slave = unpacker)
//   unpacker_fifo_if : FIFO write channel (master = unpacker, slave = FIFO)
interface unpacker_axis_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

interface unpacker_fifo_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              full;

  modport master (output wr_data, output wr_en, input full);
  modport slave  (input wr_data, input wr_en, output full);
endinterface

// File: rtl/axis_sample_unpacker.sv
// axis_sample_unpacker: takes AXI4-Stream beats carrying CHANNELS packed
// samples and emits one FIFO write per sample, channel 0 first. A single
// holding register lets the next beat be accepted on the final write of the
// current one, so sustained throughput is CHANNELS cycles per beat.
// Optional feature macro: AXIS_SAMPLE_UNPACKER_LAST_MARK_EN adds the
// fifo_wr_last output marking the final sample of a tlast beat.
module axis_sample_unpacker #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_KEEP_WIDTH = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int CHANNELS        = 2,
  parameter int FIFO_DATA_WIDTH = 16,
  parameter int SIGN_EXTEND     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  unpacker_axis_if.slave       s_axis,
  unpacker_fifo_if.master      m_fifo,
`ifdef AXIS_SAMPLE_UNPACKER_LAST_MARK_EN
  output logic                 fifo_wr_last,
`endif
  output logic [15:0]          packet_count,
  output logic [31:0]          sample_count,
  output logic                 busy
);

  localparam int USED_W = CHANNELS * SAMPLE_WIDTH;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MAX_W  = (FIFO_DATA_WIDTH > SAMPLE_WIDTH) ? FIFO_DATA_WIDTH : SAMPLE_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic {ST_IDLE, ST_UNPACK} state_t;

  // Widen (sign/zero) or narrow (keep MSBs) one sample to the FIFO word width.
  function automatic logic [FIFO_DATA_WIDTH-1:0] fn_resize(input logic [SAMPLE_WIDTH-1:0] s);
    logic signed [MAX_W-1:0] v;
    if (SIGN_EXTEND != 0) v = MAX_W'($signed(s));
    else                  v = MAX_W'($unsigned(s));
    if (FIFO_DATA_WIDTH >= SAMPLE_WIDTH) fn_resize = v[FIFO_DATA_WIDTH-1:0];
    else                                 fn_resize = v[MAX_W-1 -: FIFO_DATA_WIDTH];
  endfunction

  state_t                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_idx, w_idx_nxt;
  logic [USED_W-1:0]         r_hold;
  logic                      r_last;
  logic [15:0]               r_packet_count;
  logic [31:0]               r_sample_count;
  logic                      w_tready, w_wr, w_final, w_load;
  logic [SAMPLE_WIDTH-1:0]   w_sample;
  logic [AXIS_DATA_WIDTH-1:0] w_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] w_keep;
  logic                      w_unused;

  // tkeep and any tdata bits above the packed samples carry no information.
  assign w_tdata  = s_axis.tdata;
  assign w_keep   = s_axis.tkeep;
  assign w_unused = ^{w_tdata, w_keep};

  // Sequencer: next state, channel index, beat load and write strobes.
  always_comb begin
    w_tready    = 1'b1;
    w_wr        = 1'b0;
    w_final     = 1'b0;
    w_load      = 1'b0;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (s_axis.tvalid) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        w_tready = (r_idx == LAST_IDX) && !m_fifo.full;
        w_wr     = !m_fifo.full && !reset;
        if (!m_fifo.full) begin
          if (r_idx == LAST_IDX) begin
            w_final   = !reset;
            w_idx_nxt = '0;
            if (s_axis.tvalid) w_load = 1'b1;
            else               w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Select the sample addressed by the channel index from the held beat.
  always_comb begin
    w_sample = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_idx == IDX_W'(c)) w_sample = r_hold[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Channel index and holding register; a new beat overwrites the held one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_hold <= '0;
      r_last <= 1'b0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_load) begin
        r_hold <= w_tdata[USED_W-1:0];
        r_last <= s_axis.tlast;
      end
    end
  end

  // Status counters: samples written, and packets whose tlast beat is fully written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_packet_count <= '0;
      r_sample_count <= '0;
    end else begin
      if (w_wr)            r_sample_count <= r_sample_count + 32'd1;
      if (w_final && r_last) r_packet_count <= r_packet_count + 16'd1;
    end
  end

  assign s_axis.tready  = w_tready;
  assign m_fifo.wr_en   = w_wr;
  assign m_fifo.wr_data = fn_resize(w_sample);
  assign packet_count   = r_packet_count;
  assign sample_count   = r_sample_count;
  assign busy           = (r_state == ST_UNPACK);
`ifdef AXIS_SAMPLE_UNPACKER_LAST_MARK_EN
  assign fifo_wr_last   = w_final && r_last;
`endif

endmodule

// File: doc/axis_sample_unpacker.md
Name: axis_sample_unpacker

Overview:
- Parametrised successor to the single-sample AXIS-to-FIFO write bridge in the DMA audio path.
- Accepts AXI4-Stream beats from the DMA MM2S channel, each holding CHANNELS packed samples, and unpacks them into one FIFO write per sample in channel order.
- Feeds the audio output FIFO; handles multichannel and width-mismatched formats.
- Provides a one-beat holding register, a channel sequencer, and packet/sample status counters.

Parameters:
- AXIS_DATA_WIDTH, 32, tdata width; must be ≥ CHANNELS*SAMPLE_WIDTH.
- AXIS_KEEP_WIDTH, 4, tkeep width (ignored).
- SAMPLE_WIDTH, 16, bits per packed sample.
- CHANNELS, 2, samples per beat, range 1..8.
- FIFO_DATA_WIDTH, 16, FIFO word width.
- SIGN_EXTEND, 1, controls widening when FIFO_DATA_WIDTH > SAMPLE_WIDTH: 1 = sign-extend, 0 = zero-extend.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- axis_tdata  input  AXIS_DATA_WIDTH  packed samples; channel c occupies [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- axis_tkeep  input  AXIS_KEEP_WIDTH  unused.
- axis_tlast  input  1  last beat of DMA packet.
- axis_tvalid  input  1  beat valid.
- axis_tready  output  1  beat accept.
- fifo_wr_data  output  FIFO_DATA_WIDTH  sample to FIFO.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_full  input  1  FIFO full.
- packet_count  output  16  completed packets, i.e. tlast beats fully written; wraps.
- sample_count  output  32  total samples written; wraps.
- busy  output  1  holding register occupied.

Behaviour:
- Reset is asynchronous, active-high:
  - state = IDLE, channel index = 0, holding register = 0, last flag = 0.
  - Both counters = 0.
  - Outputs: axis_tready = 1, fifo_wr_en = 0, fifo_wr_data = 0, busy = 0.
- Reset asserted mid-beat discards any unwritten samples. The FIFO sees no partial write: fifo_wr_en drops combinationally with reset.
- State IDLE:
  - axis_tready = 1.
  - On tvalid: latch tdata and tlast, set channel index = 0, go to UNPACK.
- State UNPACK:
  - fifo_wr_en = ~fifo_full (combinational).
  - fifo_wr_data = holding[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH], resized:
    - FIFO_DATA_WIDTH > SAMPLE_WIDTH: sign- or zero-extend per SIGN_EXTEND.
    - FIFO_DATA_WIDTH < SAMPLE_WIDTH: keep the MSBs, truncate the LSBs.
  - Each write: idx++, sample_count++.
  - On the write with idx == CHANNELS-1:
    - If the last flag is set, packet_count++.
    - If a new beat is offered in the same cycle, accept it and stay in UNPACK with idx = 0. Otherwise go to IDLE.
  - axis_tready = (idx == CHANNELS-1) & ~fifo_full. This gives back-to-back beats with no bubble.
- fifo_full held high: idx freezes and no write occurs, but the data output stays stable. The write is retried each cycle, and there are no drops.
- Latency:
  - Beat accepted on edge N → first FIFO write during cycle N+1.
  - Sustained throughput is CHANNELS cycles per beat.
- CHANNELS = 1 degenerates to a one-cycle-latency pass-through at full rate.
- Counters wrap silently. busy = (state == UNPACK).
- tready never depends combinationally on tvalid.

Optional Feature:
- Macro: AXIS_SAMPLE_UNPACKER_LAST_MARK_EN.
- When defined, an extra output port is present: fifo_wr_last, output, 1 bit. It is high on the write of the final channel of a tlast beat, and 0 otherwise and in reset.
- When undefined, the port is absent. The tlast latch is still kept, because packet_count needs it.

Test Plan:
- Reset mid-UNPACK:
  - Stimulus: assert reset with idx = 1.
  - Response: wr_en = 0 immediately; tready = 1, busy = 0, and both counters = 0 after release.
- CHANNELS=2, SAMPLE_WIDTH=16, fifo_full=0:
  - Stimulus: beats 0x2222_1111 then 0x4444_3333, tvalid held.
  - Response: writes 0x1111, 0x2222, 0x3333, 0x4444 on four consecutive cycles; tready high on the cycles writing 0x2222 and 0x4444; sample_count = 4.
- fifo_full asserted for 3 cycles while idx = 1 on beat 0xBEEF_CAFE:
  - Response: wr_en = 0 and data held at 0xBEEF for all 3 cycles.
  - Response: exactly one write of 0xBEEF once full deasserts; no duplicate and no loss.
- Packet counting:
  - Stimulus: packet of 3 beats, tlast on the third.
  - Response: packet_count goes 0→1 on the cycle the sixth sample is written.
  - Response (macro defined): fifo_wr_last pulses on that write only.
- Width and extension, SAMPLE_WIDTH=16, FIFO_DATA_WIDTH=24:
  - Stimulus: sample 0x8001.
  - Response: SIGN_EXTEND=1 → 0xFF8001; SIGN_EXTEND=0 → 0x008001.
- Truncation, FIFO_DATA_WIDTH=8:
  - Stimulus: sample 0x8001.
  - Response: 0x80.
